// File: rtl/debounce_multi_if.sv
// rtl/debounce_multi_if.sv - Signal bundle between raw pins, debouncer and UI logic
interface debounce_multi_if #(
    parameter int CH     = 4,
    parameter int CNT_W  = 16,
    parameter int HOLD_W = 24
);
    logic [CH-1:0]     sw;
    logic [CNT_W-1:0]  db_limit;
    logic [HOLD_W-1:0] hold_limit;
    logic [CH-1:0]     db_level;
    logic [CH-1:0]     press_tick;
    logic [CH-1:0]     release_tick;
    logic [CH-1:0]     long_tick;

    modport slave (
        input  sw, db_limit, hold_limit,
        output db_level, press_tick, release_tick, long_tick
    );

    modport master (
        output sw, db_limit, hold_limit,
        input  db_level, press_tick, release_tick, long_tick
    );
endinterface

// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - Multi-channel debouncer with press, release and long-press ticks
module debounce_multi #(
    parameter int CH     = 4,
    parameter int CNT_W  = 16,
    parameter int HOLD_W = 24,
    parameter int SYNC   = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    debounce_multi_if.slave  bus
);
    typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_e;

    state_e            state_q [CH];
    state_e            state_d [CH];
    logic [CNT_W-1:0]  cnt_q   [CH];
    logic [CNT_W-1:0]  cnt_d   [CH];
    logic [HOLD_W-1:0] hcnt_q  [CH];
    logic [HOLD_W-1:0] hcnt_d  [CH];
    logic [SYNC-1:0]   sync_q  [CH];

    logic [CH-1:0] s;
    logic [CH-1:0] level_q, level_d;
    logic [CH-1:0] press_q, press_d;
    logic [CH-1:0] rel_q, rel_d;
    logic [CH-1:0] long_q, long_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= ZERO;
                cnt_q[i]   <= '0;
                hcnt_q[i]  <= '0;
                sync_q[i]  <= '0;
            end
            level_q <= '0;
            press_q <= '0;
            rel_q   <= '0;
            long_q  <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                hcnt_q[i]  <= hcnt_d[i];
                sync_q[i]  <= {sync_q[i][SYNC-2:0], bus.sw[i]};
            end
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            long_q  <= long_d;
        end
    end

    always_comb begin
        s       = '0;
        press_d = '0;
        rel_d   = '0;
        long_d  = '0;
        level_d = '0;
        for (int i = 0; i < CH; i++) begin
            s[i]       = sync_q[i][SYNC-1];
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            hcnt_d[i]  = hcnt_q[i];
            unique case (state_q[i])
                ZERO: begin
                    if (s[i]) begin
                        state_d[i] = WAIT1;
                        cnt_d[i]   = bus.db_limit;
                    end
                end
                WAIT1: begin
                    if (!s[i]) begin
                        state_d[i] = ZERO;
                    end else if (cnt_q[i] == '0) begin
                        state_d[i] = ONE;
                        press_d[i] = 1'b1;
                        hcnt_d[i]  = bus.hold_limit;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_W'(1);
                    end
                end
                ONE: begin
                    if (!s[i]) begin
                        state_d[i] = WAIT0;
                        cnt_d[i]   = bus.db_limit;
                    end else if (hcnt_q[i] != '0) begin
                        hcnt_d[i]  = hcnt_q[i] - HOLD_W'(1);
                        long_d[i]  = (hcnt_q[i] == HOLD_W'(1));
                    end
                end
                WAIT0: begin
                    // Bounce back to ONE keeps hcnt, so an expired long-press stays spent
                    if (s[i]) begin
                        state_d[i] = ONE;
                    end else if (cnt_q[i] == '0) begin
                        state_d[i] = ZERO;
                        rel_d[i]   = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_W'(1);
                    end
                end
                default: state_d[i] = ZERO;
            endcase
            level_d[i] = (state_d[i] == ONE) || (state_d[i] == WAIT0);
        end
    end

    assign bus.db_level     = level_q;
    assign bus.press_tick   = press_q;
    assign bus.release_tick = rel_q;
    assign bus.long_tick    = long_q;
endmodule

// File: tb/tb_debounce_multi.sv
// tb/tb_debounce_multi.sv - Scoreboard bench for debounce_multi
module tb_debounce_multi;
    localparam int CH = 4, CNT_W = 16, HOLD_W = 24, SYNC = 2;
    localparam int K_PRESS = 0, K_REL = 1, K_LONG = 2;

    typedef struct packed { int cyc; int kind; int ch; } ev_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    ev_t  exp_q[$];
    ev_t  obs_q[$];

    debounce_multi_if #(.CH(CH), .CNT_W(CNT_W), .HOLD_W(HOLD_W)) bus ();

    debounce_multi #(.CH(CH), .CNT_W(CNT_W), .HOLD_W(HOLD_W), .SYNC(SYNC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #1;
        for (int c = 0; c < CH; c++) begin
            if (bus.press_tick[c])   obs_q.push_back(ev_t'{cyc, K_PRESS, c});
            if (bus.release_tick[c]) obs_q.push_back(ev_t'{cyc, K_REL, c});
            if (bus.long_tick[c])    obs_q.push_back(ev_t'{cyc, K_LONG, c});
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_ev(input int c, input int k, input int ch);
        exp_q.push_back(ev_t'{c, k, ch});
    endtask

    task automatic test_reset;
        bus.sw = '0;
        bus.db_limit = '0;
        bus.hold_limit = '0;
        reset_n = 1'b0;
        step(3);
        n_chk++;
        if ({bus.db_level, bus.press_tick, bus.release_tick, bus.long_tick} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0000",
                     {bus.db_level, bus.press_tick, bus.release_tick, bus.long_tick});
        end
        reset_n = 1'b1;
        step(4);
        obs_q.delete();
    endtask

    task automatic test_clean_press;
        int e0;
        ev_t o, x;
        bus.db_limit = 16'd3;
        bus.hold_limit = '0;
        step(1);
        bus.sw = 4'b0001; e0 = cyc + 1;
        expect_ev(e0 + SYNC + 3 + 1, K_PRESS, 0);
        step(6);
        n_chk++;
        if (bus.db_level !== 4'b0000) begin n_fail++; $display("FAIL clean_press level_early: got %b want 0000", bus.db_level); end
        step(1);
        n_chk++;
        if (bus.db_level !== 4'b0001) begin n_fail++; $display("FAIL clean_press level_on: got %b want 0001", bus.db_level); end
        bus.sw = 4'b0000; e0 = cyc + 1;
        expect_ev(e0 + SYNC + 3 + 1, K_REL, 0);
        step(6);
        n_chk++;
        if (bus.db_level !== 4'b0001) begin n_fail++; $display("FAIL clean_press level_hold: got %b want 0001", bus.db_level); end
        step(1);
        n_chk++;
        if (bus.db_level !== 4'b0000) begin n_fail++; $display("FAIL clean_press level_off: got %b want 0000", bus.db_level); end
        step(4);
        n_chk++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL clean_press count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); x = exp_q.pop_front(); n_chk++;
            if (o !== x) begin n_fail++; $display("FAIL clean_press event: got cyc=%0d kind=%0d ch=%0d want cyc=%0d kind=%0d ch=%0d", o.cyc, o.kind, o.ch, x.cyc, x.kind, x.ch); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_bounce_reject;
        int e0;
        ev_t o, x;
        bus.db_limit = 16'd5;
        bus.sw[1] = 1'b1;
        step(4);
        bus.sw[1] = 1'b0;
        step(12);
        n_chk++;
        if (bus.db_level[1] !== 1'b0) begin n_fail++; $display("FAIL bounce_reject level: got %b want 0", bus.db_level[1]); end
        bus.sw[1] = 1'b1; e0 = cyc + 1;
        expect_ev(e0 + SYNC + 6, K_PRESS, 1);
        step(20);
        n_chk++;
        if (bus.db_level[1] !== 1'b1) begin n_fail++; $display("FAIL bounce_reject level_on: got %b want 1", bus.db_level[1]); end
        bus.sw[1] = 1'b0; e0 = cyc + 1;
        expect_ev(e0 + SYNC + 6, K_REL, 1);
        step(12);
        n_chk++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bounce_reject count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); x = exp_q.pop_front(); n_chk++;
            if (o !== x) begin n_fail++; $display("FAIL bounce_reject event: got cyc=%0d kind=%0d ch=%0d want cyc=%0d kind=%0d ch=%0d", o.cyc, o.kind, o.ch, x.cyc, x.kind, x.ch); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_long_press;
        int e0;
        ev_t o, x;
        bus.db_limit = 16'd2;
        bus.hold_limit = 24'd10;
        bus.sw[2] = 1'b1; e0 = cyc + 1;
        expect_ev(e0 + SYNC + 3, K_PRESS, 2);
        expect_ev(e0 + SYNC + 3 + 10, K_LONG, 2);
        step(30);
        bus.sw[2] = 1'b0; e0 = cyc + 1;
        expect_ev(e0 + SYNC + 3, K_REL, 2);
        step(10);
        bus.hold_limit = '0;
        bus.sw[2] = 1'b1; e0 = cyc + 1;
        expect_ev(e0 + SYNC + 3, K_PRESS, 2);
        step(30);
        bus.sw[2] = 1'b0; e0 = cyc + 1;
        expect_ev(e0 + SYNC + 3, K_REL, 2);
        step(10);
        n_chk++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL long_press count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); x = exp_q.pop_front(); n_chk++;
            if (o !== x) begin n_fail++; $display("FAIL long_press event: got cyc=%0d kind=%0d ch=%0d want cyc=%0d kind=%0d ch=%0d", o.cyc, o.kind, o.ch, x.cyc, x.kind, x.ch); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_release_bounce;
        int e0;
        ev_t o, x;
        bus.db_limit = 16'd4;
        bus.hold_limit = 24'd10;
        bus.sw[3] = 1'b1; e0 = cyc + 1;
        expect_ev(e0 + SYNC + 5, K_PRESS, 3);
        expect_ev(e0 + SYNC + 5 + 10, K_LONG, 3);
        step(25);
        bus.sw[3] = 1'b0;
        step(3);
        bus.sw[3] = 1'b1;
        step(20);
        n_chk++;
        if (bus.db_level[3] !== 1'b1) begin n_fail++; $display("FAIL release_bounce level: got %b want 1", bus.db_level[3]); end
        bus.sw[3] = 1'b0; e0 = cyc + 1;
        expect_ev(e0 + SYNC + 5, K_REL, 3);
        step(12);
        n_chk++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL release_bounce count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); x = exp_q.pop_front(); n_chk++;
            if (o !== x) begin n_fail++; $display("FAIL release_bounce event: got cyc=%0d kind=%0d ch=%0d want cyc=%0d kind=%0d ch=%0d", o.cyc, o.kind, o.ch, x.cyc, x.kind, x.ch); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back;
        int e0;
        ev_t o, x;
        bus.db_limit = 16'd1;
        bus.hold_limit = '0;
        bus.sw = 4'b1111; e0 = cyc + 1;
        for (int c = 0; c < CH; c++) expect_ev(e0 + SYNC + 2, K_PRESS, c);
        step(10);
        n_chk++;
        if (bus.db_level !== 4'b1111) begin n_fail++; $display("FAIL simultaneous level: got %b want 1111", bus.db_level); end
        bus.sw = 4'b0000; e0 = cyc + 1;
        for (int c = 0; c < CH; c++) expect_ev(e0 + SYNC + 2, K_REL, c);
        step(10);
        n_chk++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL simultaneous count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); x = exp_q.pop_front(); n_chk++;
            if (o !== x) begin n_fail++; $display("FAIL simultaneous event: got cyc=%0d kind=%0d ch=%0d want cyc=%0d kind=%0d ch=%0d", o.cyc, o.kind, o.ch, x.cyc, x.kind, x.ch); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_count;
        int e0;
        ev_t o, x;
        bus.db_limit = 16'd1;
        bus.hold_limit = '0;
        bus.sw = 4'b0010; e0 = cyc + 1;
        expect_ev(e0 + SYNC + 2, K_PRESS, 1);
        step(8);
        bus.db_limit = 16'd20;
        bus.sw = 4'b0011;
        step(8);
        reset_n = 1'b0;
        #1;
        n_chk++;
        if ({bus.db_level, bus.press_tick, bus.release_tick, bus.long_tick} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_mid outputs: got %h want 0000",
                     {bus.db_level, bus.press_tick, bus.release_tick, bus.long_tick});
        end
        bus.sw = 4'b0001;
        step(2);
        reset_n = 1'b1; e0 = cyc + 1;
        expect_ev(e0 + SYNC + 21, K_PRESS, 0);
        step(23);
        n_chk++;
        if (bus.db_level[0] !== 1'b0) begin n_fail++; $display("FAIL reset_mid level_early: got %b want 0", bus.db_level[0]); end
        step(1);
        n_chk++;
        if (bus.db_level[0] !== 1'b1) begin n_fail++; $display("FAIL reset_mid level_on: got %b want 1", bus.db_level[0]); end
        bus.sw = 4'b0000; e0 = cyc + 1;
        expect_ev(e0 + SYNC + 21, K_REL, 0);
        step(30);
        n_chk++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL reset_mid count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); x = exp_q.pop_front(); n_chk++;
            if (o !== x) begin n_fail++; $display("FAIL reset_mid event: got cyc=%0d kind=%0d ch=%0d want cyc=%0d kind=%0d ch=%0d", o.cyc, o.kind, o.ch, x.cyc, x.kind, x.ch); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce_reject();
        test_long_press();
        test_release_bounce();
        test_back_to_back();
        test_reset_mid_count();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/debounce_multi.md
# debounce_multi

Parametrised multi-channel debouncer for push-buttons and switches on the board I/O. Each channel synchronises an asynchronous input, rejects bounce with a runtime-programmable settle count, and emits a debounced level plus single-cycle press, release and long-press ticks. It sits between the raw pin inputs and the user-interface control logic, and generalises the single-channel press-only debouncer.

## Interface
- CH, 4: number of independent channels (≥1)
- CNT_W, 16: width of settle counter and `db_limit`
- HOLD_W, 24: width of long-press counter and `hold_limit`
- SYNC, 2: synchroniser flop stages per channel (≥2)

- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- sw  in  CH  raw asynchronous inputs, active-high
- db_limit  in  CNT_W  settle count L, shared by all channels
- hold_limit  in  HOLD_W  long-press count H, shared; 0 disables long-press
- db_level  out  CH  debounced level per channel
- press_tick  out  CH  one-cycle pulse on debounced 0→1
- release_tick  out  CH  one-cycle pulse on debounced 1→0
- long_tick  out  CH  one-cycle pulse when held H cycles past press

## Operation
- Per channel: SYNC-stage synchroniser producing `s[i]`, 4-state FSM, CNT_W settle counter `cnt`, HOLD_W hold counter `hcnt`, registered outputs. Channels share no state except `db_limit` and `hold_limit`.
- `db_limit` and `hold_limit` are sampled only at counter load. Changes mid-count do not affect a running count.
- FSM states and transitions:
  - ZERO (level 0): if `s`=1, go to WAIT1 and load `cnt`←L.
  - WAIT1 (level 0): if `s`=0, go to ZERO with no tick (glitch rejected). If `s`=1 and `cnt`=0, go to ONE, pulse `press_tick`, and load `hcnt`←H. Otherwise decrement `cnt`.
  - ONE (level 1): if `s`=0, go to WAIT0 and load `cnt`←L. If `s`=1 and `hcnt`≠0, decrement `hcnt`. On the 1→0 step of `hcnt`, pulse `long_tick`.
  - WAIT0 (level 1): if `s`=1, return to ONE with no tick and `hcnt` not reloaded. If `s`=0 and `cnt`=0, go to ZERO and pulse `release_tick`. Otherwise decrement `cnt`.
- `long_tick` fires at most once per press and never when H=0. A release bounce (WAIT0→ONE) does not re-arm it.
- Counters never wrap. `cnt` is only decremented when nonzero. `hcnt` stops at 0.
- `db_level` is 1 exactly in ONE and WAIT0.

## Timing
- Reset (reset_n=0, async) forces:
  - all FSMs to ZERO
  - synchroniser flops, `cnt`, `hcnt` to 0
  - `db_level`, `press_tick`, `release_tick`, `long_tick` to 0
- Reset asserted mid-count aborts it with no tick. After release, an input still held high is detected as a fresh press with full latency.
- All outputs are registered. Ticks are high for exactly one clk cycle.
- Press latency: edge 0 is the first edge sampling `sw[i]`=1, and the input is held stable. `press_tick[i]` and `db_level[i]` rise after edge SYNC+L+1.
- Release latency: symmetric. `release_tick[i]` rises and `db_level[i]` falls after edge SYNC+L+1, counted from the first edge sampling `sw[i]`=0.
- L=0 gives minimum latency SYNC+1 edges.
- `long_tick[i]` rises exactly H cycles after the `press_tick[i]` cycle, provided `s` stays 1.
- Bounce rejection: a run of `s`=1 shorter than L+2 cycles in ZERO/WAIT1 produces no press. The same holds for a run of `s`=0 in ONE/WAIT0, which produces no release.
- Simultaneous events on different channels are fully independent. Multiple tick bits may be high in the same cycle.

## Test plan
- Clean press, CH0, SYNC=2, L=3: `sw[0]` 0→1 sampled at edge 0 and held → `press_tick[0]` high only after edge 6, `db_level[0]`=1 from edge 6, other channels quiet.
- Bounce reject, L=5: `sw[1]` pulses high 4 cycles then low → no `press_tick`, `db_level[1]` stays 0. Then held high → press after edge SYNC+6.
- Long press, L=2, H=10: hold `sw[2]` → `long_tick[2]` exactly 10 cycles after `press_tick[2]`, only once. H=0 → never.
- Release bounce, L=4: in ONE, `sw[3]` low 3 cycles then high → no `release_tick`, level stays 1, no second `long_tick`. Clean low → `release_tick` after edge SYNC+5.
- Simultaneous, L=1: all channels rise on the same edge → all `press_tick` bits high in the same cycle.
- Reset mid-count, L=20: assert `reset_n`=0 during WAIT1 → all outputs 0 immediately. Release with `sw` still high → `press_tick` after full SYNC+21 edges.
